spi_slave_os: RTL
=================

# spi_slave_os

Oversampled, parametrised SPI slave for the serial-interface subsystem. All logic runs on the system clock `sclk`. `spi_clk`, `cs_n` and `mosi` are synchronised and edge-detected internally. The block supports all four SPI modes, any word width, MSB- or LSB-first ordering, back-to-back words under one chip select, and handshaked TX/RX word interfaces with underrun and overrun reporting.

## Interface
- `DATA_W`, default 8: word width in bits; legal range 2..32.
- `LSB_FIRST`, default 0: 0 = MSB shifted first; 1 = LSB shifted first (both directions).
- `SYNC_STAGES`, default 2: synchroniser depth on `spi_clk`, `cs_n` and `mosi`; minimum 2.
- `sclk` in 1: system clock; all state is updated on its rising edge.
- `reset` in 1: asynchronous, active-high.
- `mode` in 2: SPI mode; `mode[1]` = CPOL, `mode[0]` = CPHA; latched on frame start.
- `spi_clk` in 1: SPI serial clock, asynchronous to `sclk`.
- `cs_n` in 1: slave select, active-low, asynchronous.
- `mosi` in 1: serial data from the master.
- `miso` out 1: serial data to the master.
- `miso_oe` out 1: output enable for the `miso` pad driver.
- `tx_data` in DATA_W: next word to transmit.
- `tx_valid` in 1: `tx_data` is offered.
- `tx_ready` out 1: TX holding register is empty.
- `rx_data` out DATA_W: last received word.
- `rx_valid` out 1: `rx_data` holds an unacknowledged word.
- `rx_ready` in 1: consumer acknowledges `rx_data`.
- `rx_overrun` out 1: one-cycle pulse; an unacknowledged word was overwritten.
- `tx_underrun` out 1: one-cycle pulse; a word load found the TX holding register empty.
- `busy` out 1: a frame is in progress (synchronised `cs_n` is low).

## Operation
- **Input conditioning**
  - `spi_clk`, `cs_n` and `mosi` each pass through a SYNC_STAGES flop chain.
  - One further register on the synchronised `spi_clk` gives the edge detect.
  - Leading edge = transition away from CPOL. Trailing edge = transition back to CPOL.
- **TX holding register**
  - Single entry. `tx_ready` = not full.
  - Write occurs when `tx_valid && tx_ready`.
  - The register is emptied when its word is loaded into the shift register.
- **State machine: IDLE, SHIFT**
  - IDLE → SHIFT on synchronised `cs_n` falling. In the same cycle: latch `mode`, set `busy`, set `miso_oe`, load the shift register, and clear the bit counter.
  - SHIFT → IDLE on synchronised `cs_n` high, from any bit position.
- **Word load**
  - If the TX holding register is full, its word is loaded.
  - Otherwise all-zero is loaded and `tx_underrun` pulses.
- **CPHA=0**
  - First bit is on `miso` from the load cycle.
  - `mosi` is sampled on the leading edge.
  - The next TX bit is shifted out on the trailing edge.
- **CPHA=1**
  - TX bit is shifted out on the leading edge; the first leading edge presents bit 0.
  - `mosi` is sampled on the trailing edge.
- **Bit counter**
  - Width is ceil(log2(DATA_W)) + 1.
  - Increments per sample edge.
- **End of word** (on the DATA_W-th sample):
  - Write the assembled word to `rx_data` and set `rx_valid`.
  - If `rx_valid` was already set and not being acknowledged in that cycle: pulse `rx_overrun`; the new word overwrites.
  - Clear the bit counter.
  - Reload the shift register from the TX holding register (word load rule above). The reload takes the place of the next shift, so CPHA=0 presents the new word's first bit after the last sample.
- `rx_valid` clears on the cycle after `rx_ready` is high. If a new word completes in that same cycle, `rx_valid` stays 1 with the new data and no overrun is flagged.
- **Abort** (`cs_n` deasserted mid-word):
  - The partial RX word is discarded; no `rx_valid`.
  - The partially sent TX word is lost.
  - `miso_oe` = 0 and `miso` = 0.
  - Edges seen while IDLE are ignored.
- `mode` changes during SHIFT are ignored until the next frame.

## Timing
- **Reset values:** `miso` 0, `miso_oe` 0, `tx_ready` 1, `rx_data` 0, `rx_valid` 0, `rx_overrun` 0, `tx_underrun` 0, `busy` 0. The state machine is in IDLE and the holding register is empty.
- **Pin-to-action latency:** SYNC_STAGES+1 `sclk` cycles from a pin edge to its internal action.
- **`miso`:** updates one cycle after the action.
- **`rx_valid`:** rises one cycle after the final sample action.
- **Clock ratio:** each `spi_clk` phase must last at least SYNC_STAGES+2 `sclk` cycles. The master must allow the same margin between `cs_n` falling and the first `spi_clk` edge. Violation is undefined; it is not detected.
- **`tx_ready`:** rises the cycle after the load that empties the register.
- **`tx_underrun`, `rx_overrun`:** asserted for exactly one cycle each.

## Test plan
- **Mode 0, DATA_W=8, MSB-first.**
  - Stimulus: `tx_data`=0xA5 preloaded; master sends 0x3C at `sclk`/8.
  - Required: master receives 0xA5; `rx_data`=0x3C with `rx_valid` held until `rx_ready`; `tx_ready` rises after load.
- **All four modes, DATA_W=12, LSB_FIRST=1.**
  - Stimulus: exchange 0x5A3 both ways.
  - Required: bit order LSB-first on both lines; data correct in every mode.
- **Back-to-back words under one `cs_n`.**
  - Stimulus: 0x11 and 0x22 queued in time; master sends 0x81, 0x42; `rx_ready` held low.
  - Required: master gets 0x11, 0x22; `rx_overrun` pulses once; `rx_data`=0x42.
- **Underrun.**
  - Stimulus: no TX word queued at frame start.
  - Required: `tx_underrun` pulses; master reads 0x00; RX still completes.
- **Abort.**
  - Stimulus: `cs_n` raised after 5 bits.
  - Required: no `rx_valid`; `miso_oe`=0; the next full frame is correct.
- **Reset mid-frame.**
  - Stimulus: `reset` asserted during bit 3.
  - Required: all outputs at reset values immediately; the next frame is correct.

Source files
------------

// File: rtl/spi_slave_os_if.sv
// spi_slave_os bus bundle: SPI pins plus
// TX/RX word handshakes and status.
interface spi_slave_os_if #(
  parameter int DATA_W = 8
);
  logic [1:0]        mode;
  logic              spi_clk;
  logic              cs_n;
  logic              mosi;
  logic              miso;
  logic              miso_oe;
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              rx_overrun;
  logic              tx_underrun;
  logic              busy;

  modport slave (
    input  mode,
    input  spi_clk,
    input  cs_n,
    input  mosi,
    input  tx_data,
    input  tx_valid,
    input  rx_ready,
    output miso,
    output miso_oe,
    output tx_ready,
    output rx_data,
    output rx_valid,
    output rx_overrun,
    output tx_underrun,
    output busy
  );

  modport master (
    output mode,
    output spi_clk,
    output cs_n,
    output mosi,
    output tx_data,
    output tx_valid,
    output rx_ready,
    input  miso,
    input  miso_oe,
    input  tx_ready,
    input  rx_data,
    input  rx_valid,
    input  rx_overrun,
    input  tx_underrun,
    input  busy
  );
endinterface

// File: rtl/spi_slave_os.sv
// spi_slave_os: oversampled SPI slave, all four
// modes, any width, handshaked TX/RX words.
module spi_slave_os #(
  parameter int DATA_W      = 8,
  parameter int LSB_FIRST   = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic sclk,
  input  logic reset,
  spi_slave_os_if.slave bus
);

  localparam int CNT_W = $clog2(DATA_W) + 1;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t state_q;
  state_t state_n;

  logic [SYNC_STAGES-1:0] clk_sync;
  logic [SYNC_STAGES-1:0] cs_sync;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic                   clk_d;
  logic                   clk_s;
  logic                   cs_s;
  logic                   mosi_s;

  logic [1:0]        mode_q;
  logic [CNT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] rx_sr;
  logic [DATA_W-1:0] tx_sr;
  logic              tx_bit;
  logic              miso_q;

  logic [DATA_W-1:0] hold;
  logic              hold_full;

  logic [DATA_W-1:0] rx_data_q;
  logic              rx_valid_q;
  logic              rx_ovr_q;
  logic              tx_und_q;

  logic              start;
  logic              active;
  logic              rise;
  logic              fall;
  logic              lead;
  logic              trail;
  logic              sample;
  logic              launch;
  logic              last;
  logic              load;
  logic              tx_shift;
  logic              cpha_eff;
  logic [DATA_W-1:0] load_word;
  logic [DATA_W-1:0] rx_next;

  function automatic logic first_bit(
    input logic [DATA_W-1:0] w
  );
    return (LSB_FIRST != 0) ?
      w[0] : w[DATA_W-1];
  endfunction

  function automatic logic [DATA_W-1:0] shift_w(
    input logic [DATA_W-1:0] w
  );
    return (LSB_FIRST != 0) ?
      (w >> 1) : (w << 1);
  endfunction

  assign clk_s  = clk_sync[SYNC_STAGES-1];
  assign cs_s   = cs_sync[SYNC_STAGES-1];
  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  // Pin synchronisers; cs_n idles high so a
  // reset never looks like a frame start.
  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      clk_sync  <= '0;
      cs_sync   <= '1;
      mosi_sync <= '0;
      clk_d     <= 1'b0;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0],
                    bus.spi_clk};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0],
                    bus.cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0],
                    bus.mosi};
      clk_d     <= clk_s;
    end
  end

  // Frame state register.
  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  // Frame start on cs_n low, abort on cs_n high.
  always_comb begin
    state_n = state_q;
    start   = 1'b0;
    active  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!cs_s) begin
          state_n = SHIFT;
          start   = 1'b1;
        end
      end
      SHIFT: begin
        if (cs_s) begin
          state_n = IDLE;
        end else begin
          active = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Edge classification and per-cycle actions.
  always_comb begin
    rise      = clk_s & ~clk_d;
    fall      = ~clk_s & clk_d;
    lead      = mode_q[1] ? fall : rise;
    trail     = mode_q[1] ? rise : fall;
    sample    = active & (mode_q[0] ? trail : lead);
    launch    = active & (mode_q[0] ? lead : trail);
    last      = sample &&
                (bit_cnt == CNT_W'(DATA_W - 1));
    load      = start | last;
    tx_shift  = launch &&
                (mode_q[0] || (bit_cnt != '0));
    cpha_eff  = start ? bus.mode[0] : mode_q[0];
    load_word = hold_full ? hold : '0;
    if (LSB_FIRST != 0) begin
      rx_next = {mosi_s, rx_sr[DATA_W-1:1]};
    end else begin
      rx_next = {rx_sr[DATA_W-2:0], mosi_s};
    end
  end

  // TX holding register; a load empties it
  // before a same-cycle write can refill it.
  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      hold      <= '0;
      hold_full <= 1'b0;
      tx_und_q  <= 1'b0;
    end else begin
      tx_und_q <= load && !hold_full;
      if (load) begin
        hold_full <= 1'b0;
      end
      if (bus.tx_valid && !hold_full) begin
        hold      <= bus.tx_data;
        hold_full <= 1'b1;
      end
    end
  end

  // Mode latch and bit counter.
  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      mode_q  <= 2'b00;
      bit_cnt <= '0;
    end else begin
      if (start) begin
        mode_q <= bus.mode;
      end
      if (load) begin
        bit_cnt <= '0;
      end else if (sample) begin
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
    end
  end

  // RX shift and completed-word handoff.
  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      rx_sr      <= '0;
      rx_data_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ovr_q   <= 1'b0;
    end else begin
      rx_ovr_q <= last && rx_valid_q &&
                  !bus.rx_ready;
      if (start) begin
        rx_sr <= '0;
      end else if (sample) begin
        rx_sr <= rx_next;
      end
      if (last) begin
        rx_data_q  <= rx_next;
        rx_valid_q <= 1'b1;
      end else if (rx_valid_q && bus.rx_ready) begin
        rx_valid_q <= 1'b0;
      end
    end
  end

  // TX shift: CPHA=0 presents bit 0 at load,
  // CPHA=1 presents it on the first leading edge.
  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      tx_sr  <= '0;
      tx_bit <= 1'b0;
    end else begin
      if (load) begin
        if (cpha_eff) begin
          tx_sr <= load_word;
        end else begin
          tx_bit <= first_bit(load_word);
          tx_sr  <= shift_w(load_word);
        end
      end else if (tx_shift) begin
        tx_bit <= first_bit(tx_sr);
        tx_sr  <= shift_w(tx_sr);
      end
    end
  end

  // Registered miso, forced low outside a frame.
  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      miso_q <= 1'b0;
    end else begin
      miso_q <= (state_q == SHIFT) ? tx_bit : 1'b0;
    end
  end

  assign bus.miso        = miso_q;
  assign bus.miso_oe     = (state_q == SHIFT);
  assign bus.busy        = (state_q == SHIFT);
  assign bus.tx_ready    = !hold_full;
  assign bus.rx_data     = rx_data_q;
  assign bus.rx_valid    = rx_valid_q;
  assign bus.rx_overrun  = rx_ovr_q;
  assign bus.tx_underrun = tx_und_q;

endmodule
